// File: rtl/riscv_pkg.sv
// Shared types for the data-memory path: XLEN, access size codes, arbiter FSM states.
// DMEM_ARB_MISALIGN_CHECK_EN adds the ERR state and the misalignment helper's use.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } dmem_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dmem_state_e;
`endif

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [1:0]      size;
        logic            sign_ext;
    } dmem_cmd_t;

    // Size code 11 is reserved and always treated as a bad access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        return ((size == SIZE_WORD) && (addr_lsb != 2'b00)) ||
               ((size == SIZE_HALF) && addr_lsb[0]) ||
               (size == 2'b11);
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way request arbiter: fixed priority (port 0) or round-robin on contention.
// The last-grant register moves only when a grant is actually issued.
module dmem_rr_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       owner_o
);

    logic       r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                // r_last == 0 means port 0 was served last, so port 1 gets its turn.
                2'b11:   w_gnt = (RR_EN && !r_last) ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign gnt_o   = w_gnt;
    assign owner_o = w_gnt[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (|w_gnt) begin
            r_last <= w_gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester front end for data_memory: grant, one access cycle, one response cycle.
// DMEM_ARB_MISALIGN_CHECK_EN routes misaligned commands to an error response instead of memory.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [1:0][XLEN-1:0]  addr_i,
    input  logic [1:0][XLEN-1:0]  wdata_i,
    input  logic [1:0][1:0]       size_i,
    input  logic [1:0]            sign_ext_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rsp_valid_o,
    output logic [XLEN-1:0]       rdata_o,
    output logic                  err_o,
    output logic                  mem_write_en_o,
    output logic [XLEN-1:0]       mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    output logic [1:0]            mem_size_o,
    output logic                  mem_sign_ext_o,
    input  logic [XLEN-1:0]       mem_rdata_i
);

    dmem_state_e     r_state;
    dmem_cmd_t       r_cmd;
    logic            r_owner;
    logic [XLEN-1:0] r_rdata;
    logic [1:0]      r_rsp_valid;
    logic            r_err;

    logic [1:0]      w_gnt;
    logic            w_owner;
    logic            w_arb_en;
    logic            w_misalign;

    // Reset is folded in so no grant can leak out while rst_i is high.
    assign w_arb_en = (r_state == ST_IDLE) && !rst_i;

    dmem_rr_arbiter #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (w_arb_en),
        .req_i   (req_i),
        .gnt_o   (w_gnt),
        .owner_o (w_owner)
    );

`ifdef DMEM_ARB_MISALIGN_CHECK_EN
    assign w_misalign = is_misaligned(r_cmd.size, r_cmd.addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_owner     <= 1'b0;
            r_rdata     <= '0;
            r_rsp_valid <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= 2'b00;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_cmd   <= '{we:       we_i[w_owner],
                                     addr:     addr_i[w_owner],
                                     wdata:    wdata_i[w_owner],
                                     size:     size_i[w_owner],
                                     sign_ext: sign_ext_i[w_owner]};
                        r_owner <= w_owner;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Stores and rejected accesses report zero data.
                    r_rdata     <= (r_cmd.we || w_misalign) ? '0 : mem_rdata_i;
                    r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_err       <= w_misalign;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
                    r_state     <= w_misalign ? ST_ERR : ST_RESP;
`else
                    r_state     <= ST_RESP;
`endif
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o          = w_gnt;
    assign rsp_valid_o    = r_rsp_valid;
    assign rdata_o        = r_rdata;
    assign err_o          = r_err;
    assign mem_write_en_o = (r_state == ST_ACCESS) && r_cmd.we && !w_misalign;
    assign mem_addr_o     = r_cmd.addr;
    assign mem_wdata_o    = r_cmd.wdata;
    assign mem_size_o     = r_cmd.size;
    assign mem_sign_ext_o = r_cmd.sign_ext;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority with port 0 winning.
REQ-002 SHALL have port clk_i, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port req_i, input, [1:0], per-requester access request (0 = core LSU, 1 = DMA/debug).
REQ-005 SHALL have port we_i, input, [1:0], per-requester write enable.
REQ-006 SHALL have port addr_i, input, [1:0][XLEN-1:0], per-requester byte address.
REQ-007 SHALL have port wdata_i, input, [1:0][XLEN-1:0], per-requester store data.
REQ-008 SHALL have port size_i, input, [1:0][1:0], per-requester access size: 00 byte, 01 half, 10 word.
REQ-009 SHALL have port sign_ext_i, input, [1:0], per-requester load sign-extension select.
REQ-010 SHALL have port gnt_o, output, [1:0], one-hot accept pulse.
REQ-011 SHALL have port rsp_valid_o, output, [1:0], one-hot completion pulse.
REQ-012 SHALL have port rdata_o, output, XLEN, load result; valid only with rsp_valid_o.
REQ-013 SHALL have port err_o, output, 1, access error flag; valid only with rsp_valid_o.
REQ-014 SHALL have ports mem_write_en_o (1), mem_addr_o (XLEN), mem_wdata_o (XLEN), mem_size_o (2), mem_sign_ext_o (1), all outputs driving data_memory.
REQ-015 SHALL have port mem_rdata_i, input, XLEN, combinational read data returned from data_memory.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and RESP, plus ERR when compiled in.
REQ-017 IDLE: if any req_i is high, assert gnt_o for the winner in the same cycle, capture the winner's command into a register, and go to ACCESS; otherwise remain in IDLE.
REQ-018 ACCESS: drive mem_* from the captured command; mem_write_en_o = captured we; at the closing edge the store commits, mem_rdata_i is registered, and the FSM goes to RESP.
REQ-019 RESP: assert rsp_valid_o[owner] for exactly one cycle; rdata_o = registered data for a load, 0 for a store; err_o = 0; go to IDLE.
REQ-020 Latency: gnt in cycle T, memory access in T+1, response in T+2; throughput is one access per 3 cycles.
REQ-021 In all states other than ACCESS, mem_write_en_o SHALL be 0 and the other mem_* outputs SHALL hold the captured command.
REQ-022 When only one port requests, that port SHALL win regardless of RR_EN.
REQ-023 With RR_EN=1 and both ports requesting, the port not granted last SHALL win; the last-grant register updates only on a grant.
REQ-024 Requester SHALL hold req_i and its command stable until gnt_o; a request dropped before gnt_o is not serviced.
REQ-025 gnt_o SHALL never assert outside IDLE; a requester's req_i during ACCESS or RESP waits.

Reset
REQ-026 On rst_i: state = IDLE, last-grant = port 1 (port 0 wins first contention), captured command and read register = 0, all outputs = 0, effective immediately without a clock edge.
REQ-027 Reset asserted during ACCESS SHALL force mem_write_en_o low at once; the store is aborted and no response is issued.

Configuration
REQ-028 Macro DMEM_ARB_MISALIGN_CHECK_EN defined: in ACCESS, a captured command with word and addr[1:0]!=0, half and addr[0]!=0, or size=11 SHALL NOT write memory and SHALL go to ERR instead of RESP; ERR pulses rsp_valid_o[owner] with err_o=1 and rdata_o=0, then goes to IDLE. Total latency is the same 3 cycles.
REQ-029 Macro DMEM_ARB_MISALIGN_CHECK_EN undefined: no ERR state; err_o is tied 0; commands pass to memory unchecked.

Structure
REQ-030 XLEN, the size encodings (SIZE_BYTE/HALF/WORD), and the FSM state enum typedef SHALL reside in riscv_pkg.
REQ-031 Arbitration SHALL be a sub-module dmem_rr_arbiter (2-way, RR_EN parameter, last-grant register inside); the FSM and command register stay in dmem_arbiter.

Verification
REQ-032 Port 0 word store: addr 0x10, data 0xDEADBEEF -> gnt_o=01 at T, mem_write_en_o=1 at T+1, rsp_valid_o=01 at T+2; a subsequent word load of 0x10 returns rdata_o=0xDEADBEEF.
REQ-033 Both ports request continuously from reset (RR_EN=1) -> grant order 0,1,0,1; (RR_EN=0) -> port 0 every time while req_i[0] stays high.
REQ-034 Byte store 0x5A to 0x13, then byte load of 0x13 with sign_ext=0 -> 0x0000005A; value 0xA5 with sign_ext=1 -> 0xFFFFFFA5; other bytes of the word unchanged.
REQ-035 rst_i asserted in the ACCESS cycle of a store to 0x20 (previously 0x11111111) -> mem_write_en_o drops at once, no rsp_valid_o, later load of 0x20 returns 0x11111111.
REQ-036 With DMEM_ARB_MISALIGN_CHECK_EN: word store to 0x22 -> rsp_valid with err_o=1, memory unchanged; half load of 0x22 -> err_o=0 and correct data.
